// File: rtl/stream_arb2to1.sv
// Two-input valid/ready stream arbiter with a registered output stage.
// Ports: clk, rst (async high); in1_*/in2_* sources; out_* sink; sel (1=in1).
module stream_arb2to1 #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in1_valid,
    output logic                   in1_ready,
    input  logic [INPUT_WIDTH-1:0] in1_data,
    input  logic                   in1_last,
    input  logic                   in2_valid,
    output logic                   in2_ready,
    input  logic [INPUT_WIDTH-1:0] in2_data,
    input  logic                   in2_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic                   sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK1 = 2'd1,
        LOCK2 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    // 1 = in1 wins a tie, 0 = in2 wins a tie
    logic   ptr;
    logic   ptr_nxt;

    logic   slot_free;
    logic   grant1;
    logic   grant2;
    logic   xfer1;
    logic   xfer2;

    // Output slot can take a beat if empty or being drained this cycle.
    assign slot_free = !out_valid || out_ready;

    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        unique case (state)
            IDLE: begin
                grant1 = in1_valid && (!in2_valid || ptr);
                grant2 = in2_valid && (!in1_valid || !ptr);
            end
            LOCK1: grant1 = 1'b1;
            LOCK2: grant2 = 1'b1;
            default: begin
                grant1 = 1'b0;
                grant2 = 1'b0;
            end
        endcase
    end

    assign in1_ready = !rst && grant1 && slot_free;
    assign in2_ready = !rst && grant2 && slot_free;
    assign xfer1     = in1_valid && in1_ready;
    assign xfer2     = in2_valid && in2_ready;

    // Grant stays locked until the packet's last beat is accepted;
    // the tie-break pointer only moves on that last beat.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (xfer1) begin
            if (in1_last) begin
                state_nxt = IDLE;
                ptr_nxt   = 1'b0;
            end else begin
                state_nxt = LOCK1;
            end
        end else if (xfer2) begin
            if (in2_last) begin
                state_nxt = IDLE;
                ptr_nxt   = 1'b1;
            end else begin
                state_nxt = LOCK2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 1'b1;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // A new beat overwrites the slot even while the old one drains,
    // giving back-to-back beats without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sel       <= 1'b0;
        end else if (xfer1) begin
            out_valid <= 1'b1;
            out_data  <= in1_data;
            out_last  <= in1_last;
            sel       <= 1'b1;
        end else if (xfer2) begin
            out_valid <= 1'b1;
            out_data  <= in2_data;
            out_last  <= in2_last;
            sel       <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb2to1.sv
// Directed testbench for stream_arb2to1 with a queue-based scoreboard.
// Stimulus pushes expected beats; a negedge monitor pops and compares.
module tb_stream_arb2to1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] in1_data;
    logic       in1_last;
    logic       in2_valid;
    logic       in2_ready;
    logic [7:0] in2_data;
    logic       in2_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       sel;

    typedef struct packed {
        logic       sel;
        logic       last;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    n_vec = 0;
    int    n_bad = 0;

    stream_arb2to1 #(.INPUT_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in2_valid (in2_valid),
        .in2_ready (in2_ready),
        .in2_data  (in2_data),
        .in2_last  (in2_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic l, input logic [7:0] d);
        beat_t b;
        b.sel  = s;
        b.last = l;
        b.data = d;
        exp_q.push_back(b);
    endtask

    // Monitor: a beat is consumed when out_valid && out_ready before an edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL beat: got %0h (sel %0b) expected none",
                         out_data, sel);
            end else begin
                mon_e = exp_q.pop_front();
                if ({sel, out_last, out_data} !== mon_e) begin
                    n_bad++;
                    $display("FAIL beat: got sel=%0b last=%0b data=%0h expected sel=%0b last=%0b data=%0h",
                             sel, out_last, out_data,
                             mon_e.sel, mon_e.last, mon_e.data);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in1_valid = 1'b1;
        in1_data  = 8'h00;
        in1_last  = 1'b0;
        in2_valid = 1'b0;
        in2_data  = 8'h00;
        in2_last  = 1'b0;
        out_ready = 1'b0;

        // Reset then idle
        @(negedge clk);
        chk("rst_in1_ready", in1_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        in1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_sel", sel, 0);
        chk("idle_in1_ready", in1_ready, 0);
        chk("idle_in2_ready", in2_ready, 0);
        chk("idle_out_data", out_data, 8'h00);
        cyc();

        // Alternation of single-beat packets
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hA5; in1_last = 1'b1;
        in2_valid = 1'b1; in2_data = 8'h3C; in2_last = 1'b1;
        push(1, 1, 8'hA5);
        push(0, 1, 8'h3C);
        push(1, 1, 8'hA5);
        push(0, 1, 8'h3C);
        push(1, 1, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("alt_in1_ready", in1_ready, (i % 2 == 0) ? 1 : 0);
            chk("alt_in2_ready", in2_ready, (i % 2 == 1) ? 1 : 0);
            if (i > 0) chk("alt_no_bubble", out_valid, 1);
            cyc();
        end
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        @(negedge clk);
        chk("alt_last_valid", out_valid, 1);
        cyc();
        @(negedge clk);
        chk("alt_drained", out_valid, 0);
        cyc();

        // Packet lock with backpressure
        in1_valid = 1'b1; in1_data = 8'h10; in1_last = 1'b0;
        push(1, 0, 8'h10);
        push(1, 0, 8'h11);
        push(1, 0, 8'h12);
        push(1, 1, 8'h13);
        push(0, 1, 8'hFF);
        @(negedge clk);
        chk("lock_in1_ready0", in1_ready, 1);
        cyc();
        in1_data  = 8'h11;
        in2_valid = 1'b1; in2_data = 8'hFF; in2_last = 1'b1;
        @(negedge clk);
        chk("lock_in1_ready1", in1_ready, 1);
        chk("lock_in2_ready1", in2_ready, 0);
        cyc();
        in1_data  = 8'h12;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_out_data", out_data, 8'h11);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in1_ready", in1_ready, 0);
            chk("bp_in2_ready", in2_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("lock_in1_ready2", in1_ready, 1);
        chk("lock_in2_ready2", in2_ready, 0);
        cyc();
        in1_data = 8'h13; in1_last = 1'b1;
        @(negedge clk);
        chk("lock_in2_ready3", in2_ready, 0);
        cyc();
        in1_valid = 1'b0;
        @(negedge clk);
        chk("unlock_in2_ready", in2_ready, 1);
        cyc();
        in2_valid = 1'b0;
        cyc();

        // Gap inside an in2 packet
        in2_valid = 1'b1; in2_data = 8'h01; in2_last = 1'b0;
        push(0, 0, 8'h01);
        push(0, 1, 8'h02);
        push(1, 1, 8'h55);
        @(negedge clk);
        chk("gap_in2_ready0", in2_ready, 1);
        cyc();
        in2_valid = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h55; in1_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("gap_in1_ready", in1_ready, 0);
            cyc();
        end
        in2_valid = 1'b1; in2_data = 8'h02; in2_last = 1'b1;
        @(negedge clk);
        chk("gap_in2_ready1", in2_ready, 1);
        chk("gap_in1_blocked", in1_ready, 0);
        cyc();
        in2_valid = 1'b0;
        @(negedge clk);
        chk("gap_in1_next", in1_ready, 1);
        cyc();
        in1_valid = 1'b0;
        cyc();
        cyc();

        // Reset mid-packet
        out_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h77; in1_last = 1'b0;
        @(negedge clk);
        chk("mid_in1_ready", in1_ready, 1);
        cyc();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in1_ready", in1_ready, 0);
        cyc();
        rst       = 1'b0;
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h88; in1_last = 1'b1;
        in2_valid = 1'b1; in2_data = 8'h99; in2_last = 1'b1;
        push(1, 1, 8'h88);
        push(0, 1, 8'h99);
        @(negedge clk);
        chk("post_rst_in1_ready", in1_ready, 1);
        chk("post_rst_in2_ready", in2_ready, 0);
        cyc();
        cyc();
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        repeat (3) cyc();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
